cla_group_seq_adder: RTL and testbench
======================================

# cla_group_seq_adder

Multi-cycle adder that drives the group carry-lookahead interface from the operand side. It captures two operands and a carry-in with a valid/ready handshake, then forms generate/propagate vectors. It resolves one GROUP-bit lookahead group per clock, LSB group first, threading the group carry through a register. It returns sum and carry-out with a valid/ready handshake, serving area-constrained datapaths where a full-width lookahead tree is too large.

## Interface
- WIDTH, 12, operand width; must be a positive multiple of GROUP
- GROUP, 3, bits resolved per cycle by the lookahead step
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_valid  in  1  operands offered
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  a+b+cin, low WIDTH bits
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow (only with CLA_SEQ_OVF_EN)

## Operation
- NG = WIDTH/GROUP group steps per operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b, cin; clear the group index and sum register; go to RUN.
  - RUN: each cycle process group k = index. Compute g=a&b and p=a^b over bits [k*GROUP +: GROUP].
    - Internal carries: c[0]=g[0]|(p[0]&cr); c[i]=g[i]|(p[i]&c[i-1]). cr is the carry register, initialised from cin.
    - Sum bits: s[0]=p[0]^cr; s[i]=p[i]^c[i-1].
    - Write s into sum[k*GROUP +: GROUP]; cr <= c[GROUP-1]; index++.
    - After group NG-1, go to DONE with cout=cr.
  - DONE: out_valid=1. On out_ready, go to IDLE. A new operation is not accepted in the same cycle.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and operand inputs are don't-care after capture.
- sum and cout hold stable throughout DONE. They keep their value after returning to IDLE until the next capture clears sum.
- Reset values (after a clock edge with rst_n=0):
  - state=IDLE; index=0; cr=0.
  - sum=0; cout=0; ovf=0; out_valid=0.
  - in_ready is forced 0 while rst_n=0 and is 1 in the first cycle after reset is released.
- Reset mid-operation (RUN or DONE): the operation is abandoned with no out_valid pulse; all outputs take reset values.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the true carry of a+b+cin. No saturation.

## Timing
- Accept edge E (in_valid & in_ready sampled high).
- Group k is written at edge E+1+k.
- out_valid rises after edge E+NG. For WIDTH=12, GROUP=3 this is 4 edges after accept.
- Minimum throughput is one operation per NG+2 cycles: accept, NG RUN cycles, one DONE cycle with out_ready=1.
- out_valid is registered. in_ready is a decode of state and rst_n. No combinational path runs from in_valid or out_ready to any output.

## Configuration
- CLA_SEQ_OVF_EN defined: port ovf exists.
  - It is registered on entry to DONE as c[GROUP-2]^c[GROUP-1] of the last group, i.e. carry into the MSB XOR carry out of the MSB.
  - It is valid with out_valid and reset to 0.
- CLA_SEQ_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Structure
- Shared package cla_pkg holds:
  - the FSM state encoding (IDLE/RUN/DONE);
  - the default GROUP constant;
  - a function returning NG and the index width clog2(NG).
- Sub-module cla_group_step: combinational GROUP-bit g/p formation, lookahead chain and sum. Inputs are a and b slices plus carry-in; outputs are the sum slice, group carry-out and the internal carry vector used for ovf. It is instantiated once; the FSM muxes slices by index.

## Test plan
All cases use WIDTH=12, GROUP=3.
- Reset: hold rst_n=0 for 2 cycles, then release. Required: out_valid=0, sum=0x000, cout=0, in_ready=0 during reset and 1 in the first cycle after release.
- Basic add: a=0x0FF, b=0x001, cin=0. Required: sum=0x100, cout=0, out_valid first high exactly 4 edges after accept.
- Full carry ripple across all groups: a=0xFFF, b=0x000, cin=1. Required: sum=0x000, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands. Required: sum and cout stable, in_ready=0, new operands not captured; one cycle after out_ready=1, in_ready=1.
- Reset mid-RUN: assert rst_n=0 at the edge that would write group 2 of a=0x123, b=0x456. Required: next cycle state IDLE and all outputs at reset values; out_valid never asserted for that operation.
- With CLA_SEQ_OVF_EN defined:
  - a=0x7FF, b=0x001, cin=0 -> sum=0x800, cout=0, ovf=1.
  - a=0xFFF, b=0x001 -> sum=0x000, cout=1, ovf=0.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg
//   Shared definitions for the sequential group carry-lookahead adder:
//   FSM state encoding, default group size and sizing helpers.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_e;

    localparam int unsigned CLA_GROUP_DFLT = 3;

    // Number of lookahead groups (one per RUN cycle) for an operation.
    function automatic int unsigned cla_ng(input int unsigned width,
                                           input int unsigned group);
        return width / group;
    endfunction

    // Width of the group index register; never narrower than one bit.
    function automatic int unsigned cla_idx_w(input int unsigned width,
                                              input int unsigned group);
        int unsigned ng;
        ng = width / group;
        return (ng > 1) ? $clog2(ng) : 1;
    endfunction

endpackage

// File: rtl/cla_group_step.sv
// cla_group_step
//   Combinational GROUP-bit lookahead step: forms generate/propagate,
//   resolves the carry chain from c_i and produces the sum slice.
// Ports:
//   a_i, b_i  [GROUP-1:0]  operand slices
//   c_i                    carry into the group
//   s_o       [GROUP-1:0]  sum slice
//   c_o                    carry out of the group
//   carry_o   [GROUP-1:0]  carry out of each bit (carry_o[i] = c[i])
module cla_group_step #(
    parameter int unsigned GROUP = 3
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_i,
    output logic [GROUP-1:0] s_o,
    output logic             c_o,
    output logic [GROUP-1:0] carry_o
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic             cprev;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        s_o     = '0;
        carry_o = '0;
        cprev   = c_i;
        for (int unsigned i = 0; i < GROUP; i++) begin
            s_o[i]     = p[i] ^ cprev;
            carry_o[i] = g[i] | (p[i] & cprev);
            cprev      = carry_o[i];
        end
    end

    assign c_o = carry_o[GROUP-1];

endmodule

// File: rtl/cla_group_seq_adder.sv
// cla_group_seq_adder
//   Multi-cycle adder: captures a, b, cin on a valid/ready handshake,
//   resolves one GROUP-bit lookahead group per clock (LSB group first)
//   threading the group carry through a register, then presents
//   sum/cout on a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready decoded from state, rst_n)
//   a, b [WIDTH-1:0], cin operands and carry-in
//   out_valid / out_ready result handshake (out_valid registered)
//   sum [WIDTH-1:0], cout a+b+cin and its carry out
//   ovf                   signed overflow, present only with CLA_SEQ_OVF_EN
// Configuration macro: CLA_SEQ_OVF_EN
// WIDTH must be a positive multiple of GROUP.
module cla_group_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned GROUP = CLA_GROUP_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NG = cla_ng(WIDTH, GROUP);
    localparam int unsigned IW = cla_idx_w(WIDTH, GROUP);
    localparam logic [IW-1:0] LAST_IDX = IW'(NG - 1);

    cla_state_e       state_q;
    logic [IW-1:0]    idx_q;
    logic             cr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;

    logic [GROUP-1:0] a_sl;
    logic [GROUP-1:0] b_sl;
    logic [GROUP-1:0] grp_sum_d;
    logic             grp_cout_d;
`ifdef CLA_SEQ_OVF_EN
    logic [GROUP-1:0] grp_carry;
    logic             msb_cin;
    logic             ovf_q;
`else
    logic [GROUP-1:0] grp_carry_unused;
`endif

    assign a_sl = a_q[idx_q*GROUP +: GROUP];
    assign b_sl = b_q[idx_q*GROUP +: GROUP];

    cla_group_step #(
        .GROUP (GROUP)
    ) u_step (
        .a_i     (a_sl),
        .b_i     (b_sl),
        .c_i     (cr_q),
        .s_o     (grp_sum_d),
        .c_o     (grp_cout_d),
`ifdef CLA_SEQ_OVF_EN
        .carry_o (grp_carry)
`else
        .carry_o (grp_carry_unused)
`endif
    );

`ifdef CLA_SEQ_OVF_EN
    // Carry into the MSB: internal carry of bit GROUP-2, or the group
    // carry-in when a group is a single bit.
    if (GROUP > 1) begin : g_msb_cin
        assign msb_cin = grp_carry[GROUP-2];
    end else begin : g_msb_cin_single
        assign msb_cin = cr_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cr_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        cr_q    <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*GROUP +: GROUP] <= grp_sum_d;
                    cr_q  <= grp_cout_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        cout_q      <= grp_cout_d;
                        out_valid_q <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
                        ovf_q       <= msb_cin ^ grp_cout_d;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_group_seq_adder.sv
// tb_cla_group_seq_adder
//   Directed bench for cla_group_seq_adder (WIDTH=12, GROUP=3).
//   Overflow cases are included when CLA_SEQ_OVF_EN is defined.
module tb_cla_group_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] sum;
    logic        cout;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cla_group_seq_adder #(
        .WIDTH (12),
        .GROUP (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation from IDLE and wait (bounded) for out_valid.
    task automatic do_op(input logic [11:0] av, input logic [11:0] bv, input logic cv);
        int cnt;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("op_done_in_time", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset held for two edges
        tick();
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {20'd0, sum}, 32'h000);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_in_ready_low2", {31'd0, in_ready}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic add with exact latency: out_valid rises 4 edges after accept
        a        = 12'h0FF;
        b        = 12'h001;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("basic_in_ready_run", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("basic_latency_low", {31'd0, out_valid}, 32'd0);
            tick();
        end
        chk("basic_latency_high", {31'd0, out_valid}, 32'd1);
        chk("basic_sum", {20'd0, sum}, 32'h100);
        chk("basic_cout", {31'd0, cout}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("basic_release_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_release_ready", {31'd0, in_ready}, 32'd1);

        // Full ripple across all groups, then backpressure in DONE
        do_op(12'hFFF, 12'h000, 1'b1);
        chk("ripple_sum", {20'd0, sum}, 32'h000);
        chk("ripple_cout", {31'd0, cout}, 32'd1);
        a        = 12'h555;
        b        = 12'h111;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_sum", {20'd0, sum}, 32'h000);
            chk("bp_cout", {31'd0, cout}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        // in_valid still high across the release edge: must not capture
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_sum_held", {20'd0, sum}, 32'h000);
        chk("bp_release_cout_held", {31'd0, cout}, 32'd1);
        tick();
        chk("bp_idle_no_capture", {20'd0, sum}, 32'h000);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Further patterns
        do_op(12'h123, 12'h456, 1'b1);
        chk("p1_sum", {20'd0, sum}, 32'h57A);
        chk("p1_cout", {31'd0, cout}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        do_op(12'h800, 12'h800, 1'b0);
        chk("p2_sum", {20'd0, sum}, 32'h000);
        chk("p2_cout", {31'd0, cout}, 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        do_op(12'hABC, 12'h135, 1'b0);
        chk("p3_sum", {20'd0, sum}, 32'hBF1);
        chk("p3_cout", {31'd0, cout}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifdef CLA_SEQ_OVF_EN
        do_op(12'h7FF, 12'h001, 1'b0);
        chk("ovf1_sum", {20'd0, sum}, 32'h800);
        chk("ovf1_cout", {31'd0, cout}, 32'd0);
        chk("ovf1_ovf", {31'd0, ovf}, 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        do_op(12'hFFF, 12'h001, 1'b0);
        chk("ovf2_sum", {20'd0, sum}, 32'h000);
        chk("ovf2_cout", {31'd0, cout}, 32'd1);
        chk("ovf2_ovf", {31'd0, ovf}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

        // Reset mid-RUN: rst_n low at the edge that would write group 2
        a        = 12'h123;
        b        = 12'h456;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();                 // accept edge E
        in_valid = 1'b0;
        tick();                 // E+1: group 0
        chk("mid_sum_g0", {20'd0, sum}, 32'h001);
        tick();                 // E+2: group 1
        chk("mid_sum_g1", {20'd0, sum}, 32'h039);
        rst_n = 1'b0;
        tick();                 // E+3: reset sampled
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {20'd0, sum}, 32'h000);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_post_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("mid_idle_sum", {20'd0, sum}, 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
